uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter BAUD_DIV, default 5208, clk cycles per serial bit time; legal range 4..16383.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 Reset  input  1  reset, synchronous, active-high.
REQ-004 Send  input  1  transmit request; four-phase handshake with Sent.
REQ-005 Din  input  8  byte to transmit; sampled only on frame accept.
REQ-006 Sent  output  1  frame-complete acknowledge.
REQ-007 Busy  output  1  high from frame accept until return to IDLE.
REQ-008 Sout  output  1  serial line, idle-high, driven directly from a flop.

Function
REQ-009 FSM states SHALL be IDLE, START, DATA, PAR, STOP and ACK.
REQ-010 IDLE: Sout=1, Busy=0, Sent=0, baud timer held at 0; on Send=1, latch Din into shift register, clear bit counter, go START.
REQ-011 Latency: Send sampled high at edge N SHALL produce Sout=0 and Busy=1 from edge N+1.
REQ-012 Baud timer counts 0..BAUD_DIV-1 and wraps; each bit SHALL hold Sout for exactly BAUD_DIV cycles.
REQ-013 START: Sout=0 for one bit time, then DATA.
REQ-014 DATA: 8 bits LSB first; shift right at each bit-time end; 3-bit counter; after bit 7 go PAR (macro defined) or STOP (macro undefined).
REQ-015 PAR: Sout = odd parity, i.e. XNOR-reduce of latched byte, so the count of ones over data plus parity is odd; one bit time, then STOP.
REQ-016 STOP: Sout=1 for one bit time, then ACK.
REQ-017 ACK: Sout=1, Busy=1, Sent=1; go IDLE on the first cycle Send=0. Sent SHALL drop the cycle after.
REQ-018 If Send is already 0 on entering ACK, Sent SHALL be high for exactly one cycle.
REQ-019 Send held high SHALL keep ACK indefinitely. No second frame starts until Send has been seen low.
REQ-020 Din changes and Send deassertion during START..STOP SHALL NOT alter the frame in flight.
REQ-021 Back-to-back: Send reasserted in the cycle after ACK->IDLE starts a new frame one cycle later. Minimum line idle between frames is one cycle beyond the stop bit.
REQ-022 Illegal or unreachable state encodings SHALL recover to IDLE on the next edge.

Reset
REQ-023 Reset=1 at any edge, including mid-frame: state IDLE, Sout=1, Sent=0, Busy=0, baud timer 0, bit counter 0, effective next edge.
REQ-024 Reset SHALL take priority over Send. A frame interrupted by Reset is abandoned, not resumed.

Configuration
REQ-025 Macro UART_TX_PARITY_EN defined: frame = start + 8 data + odd parity + stop, 11 bit times.
REQ-026 UART_TX_PARITY_EN undefined: PAR state and parity logic absent; frame = start + 8 data + stop, 10 bit times.

Verification (BAUD_DIV=4 unless stated)
REQ-027 Parity on, Send=1 with Din=0x55 -> Sout, sampled mid-bit: 0,1,0,1,0,1,0,1,0,1(par),1(stop); Sent rises 44 cycles after first Sout=0.
REQ-028 Parity on, Din=0x07 -> parity bit 0; Din=0x00 -> parity bit 1. Parity off, Din=0x00 -> 10-bit frame with no parity bit, total 40 cycles.
REQ-029 Send held high for 200 cycles -> exactly one frame, Sent high until Send drops, Sent low one cycle later, no second start bit.
REQ-030 Send pulsed one cycle, then Din changed to 0xFF mid-frame -> transmitted byte equals originally latched 0xA3; Sent is a one-cycle pulse.
REQ-031 Reset asserted during data bit 3 -> Sout=1, Busy=0 next edge. A new Send with Din=0x3C then gives a clean full frame.
REQ-032 BAUD_DIV=5208, Din=0xC1 -> every bit width measured at exactly 5208 cycles.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx -- byte-wide UART transmitter with a four-phase Send/Sent handshake.
//
// Frame: one start bit (0), eight data bits LSB first, an optional odd parity
// bit, and one stop bit (1). Each bit lasts BAUD_DIV clk cycles. The serial
// line Sout idles high and comes straight from a flop, so it is glitch-free.
//
// Optional feature: define UART_TX_PARITY_EN to insert an odd-parity bit
// between the last data bit and the stop bit (11 bit times per frame).
// Without the macro the parity state and logic are absent (10 bit times).
//
// Handshake: a high Send in IDLE accepts the frame and latches Din. Once the
// stop bit completes, Sent rises and stays high until Send is seen low. This
// guarantees one frame per request even if Send is held high for a long time.

module uart_tx #(
   parameter int BAUD_DIV = 5208
) (
   input  logic       clk,
   input  logic       Reset,
   input  logic       Send,
   input  logic [7:0] Din,
   output logic       Sent,
   output logic       Busy,
   output logic       Sout
);

   // The baud timer is 14 bits wide so every legal divider (4..16383) fits.
   localparam int          BAUD_W    = 14;
   localparam logic [13:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
`ifdef UART_TX_PARITY_EN
      PAR   = 3'd3,
`endif
      STOP  = 3'd4,
      ACK   = 3'd5
   } state_e;

   state_e              state_q, state_d;
   logic [BAUD_W-1:0]   baud_q,  baud_d;
   logic [2:0]          bit_cnt_q, bit_cnt_d;
   logic [7:0]          shift_q, shift_d;
   logic                sout_q,  sout_d;
   logic                busy_q,  busy_d;
   logic                sent_q,  sent_d;
`ifdef UART_TX_PARITY_EN
   logic                parity_q, parity_d;
`endif

   logic                bit_end;

   // The current bit time ends on the last count of the baud timer.
   assign bit_end = (baud_q == BAUD_LAST);

   // Next-state and next-output logic for the frame sequencer.
   always_comb begin
      // NOTE: every signal gets a default before the case so that no path leaves it unassigned and a latch is inferred.
      state_d   = state_q;
      baud_d    = bit_end ? '0 : baud_q + BAUD_W'(1);
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      sout_d    = sout_q;
      busy_d    = busy_q;
      sent_d    = sent_q;
`ifdef UART_TX_PARITY_EN
      parity_d  = parity_q;
`endif

      case (state_q)
         IDLE: begin
            baud_d    = '0;
            bit_cnt_d = '0;
            sout_d    = 1'b1;
            busy_d    = 1'b0;
            sent_d    = 1'b0;
            if (Send) begin
               // Accept the frame: the byte is captured here and never again.
               shift_d  = Din;
`ifdef UART_TX_PARITY_EN
               // Odd parity: the bit makes the total count of ones odd.
               parity_d = ~^Din;
`endif
               state_d  = START;
               sout_d   = 1'b0;
               busy_d   = 1'b1;
            end
         end

         START: begin
            if (bit_end) begin
               state_d = DATA;
               sout_d  = shift_q[0];
            end
         end

         DATA: begin
            if (bit_end) begin
               if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = PAR;
                  sout_d  = parity_q;
`else
                  state_d = STOP;
                  sout_d  = 1'b1;
`endif
               end else begin
                  // Shift right so the next data bit sits in position 0.
                  shift_d   = {1'b0, shift_q[7:1]};
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  sout_d    = shift_q[1];
               end
            end
         end

`ifdef UART_TX_PARITY_EN
         PAR: begin
            if (bit_end) begin
               state_d = STOP;
               sout_d  = 1'b1;
            end
         end
`endif

         STOP: begin
            if (bit_end) begin
               state_d = ACK;
               sout_d  = 1'b1;
               sent_d  = 1'b1;
            end
         end

         ACK: begin
            baud_d = '0;
            sout_d = 1'b1;
            busy_d = 1'b1;
            sent_d = 1'b1;
            // Stay here until the requester drops Send; one frame per request.
            if (!Send) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               sent_d  = 1'b0;
            end
         end

         default: begin
            // Unused encodings fall back to a quiet idle line.
            state_d   = IDLE;
            baud_d    = '0;
            bit_cnt_d = '0;
            sout_d    = 1'b1;
            busy_d    = 1'b0;
            sent_d    = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous, active-high reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values of its peers.
      if (Reset) begin
         state_q   <= IDLE;
         baud_q    <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         sout_q    <= 1'b1;
         busy_q    <= 1'b0;
         sent_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         baud_q    <= baud_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         sout_q    <= sout_d;
         busy_q    <= busy_d;
         sent_q    <= sent_d;
`ifdef UART_TX_PARITY_EN
         parity_q  <= parity_d;
`endif
      end
   end

   assign Sout = sout_q;
   assign Busy = busy_q;
   assign Sent = sent_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx -- randomized, scoreboard-checked bench for uart_tx.
//
// A fast instance (BAUD_DIV=4) carries directed and random traffic; a monitor
// decodes its serial line independently and compares each frame against the
// expected byte queued at request time. A slow instance (BAUD_DIV=5208)
// measures every bit width of one frame. Honors UART_TX_PARITY_EN.

module tb_uart_tx;

   localparam int DIV      = 4;
   localparam int DIV_SLOW = 5208;
`ifdef UART_TX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif

   logic       clk;
   logic       rst, send, sent, busy, sout;
   logic [7:0] din;
   logic       rst_s, send_s, sent_s, busy_s, sout_s;
   logic [7:0] din_s;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] exp_q[$];

   uart_tx #(.BAUD_DIV(DIV)) dut (
      .clk(clk), .Reset(rst), .Send(send), .Din(din),
      .Sent(sent), .Busy(busy), .Sout(sout)
   );

   uart_tx #(.BAUD_DIV(DIV_SLOW)) dut_slow (
      .clk(clk), .Reset(rst_s), .Send(send_s), .Din(din_s),
      .Sent(sent_s), .Busy(busy_s), .Sout(sout_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog: the run must end on its own.
   initial begin
      #900_000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: the line image of a frame, bit 0 first on the wire.
   function automatic logic [10:0] frame_of(input logic [7:0] b);
      logic [10:0] f;
      f = '0;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[1+i] = b[i];
`ifdef UART_TX_PARITY_EN
      f[9]  = ($countones(b) % 2 == 0);
      f[10] = 1'b1;
`else
      f[9]  = 1'b1;
`endif
      return f;
   endfunction

   // Monitor: decode every frame on the fast line and compare with the scoreboard.
   initial begin
      logic [10:0] got, expf;
      logic [7:0]  b;
      int          bad;
      bit          aborted;
      forever begin
         @(negedge clk);
         if (sout === 1'b0) begin
            got     = '0;
            bad     = 0;
            aborted = 1'b0;
            got[0]  = sout;
            if (busy !== 1'b1 || sent !== 1'b0) bad++;
            for (int i = 1; i <= FRAME_BITS * DIV; i++) begin
               @(posedge clk);
               if (rst) begin
                  aborted = 1'b1;
                  break;
               end
               @(negedge clk);
               if (i < FRAME_BITS * DIV) begin
                  if (i % DIV == 0) got[i / DIV] = sout;
                  else if (sout !== got[i / DIV]) bad++;
                  if (busy !== 1'b1 || sent !== 1'b0) bad++;
               end else begin
                  check("mon_sent_at_frame_end", 32'(sent), 32'd1);
               end
            end
            if (!aborted) begin
               check("mon_bit_stability", 32'(bad), 32'd0);
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL mon_unexpected_frame: got frame %0h, expected none (t=%0t)", got, $time);
               end else begin
                  b    = exp_q.pop_front();
                  expf = frame_of(b);
                  check("mon_frame_bits", 32'(got), 32'(expf));
               end
            end
         end
      end
   end

   // Issue one frame from a negedge with the DUT idle. hold_extra < 0 pulses
   // Send for one cycle; otherwise Send stays high until hold_extra cycles
   // after Sent rises. Returns at the negedge where the DUT is idle again.
   task automatic send_frame(input logic [7:0] b, input int hold_extra, input bit scramble);
      int n;
      check("idle_before_send", 32'({busy, sent, sout}), 32'b001);
      din  = b;
      send = 1'b1;
      exp_q.push_back(b);
      @(negedge clk);
      check("accept_latency", 32'({sout, busy}), 32'b01);
      if (hold_extra < 0) send = 1'b0;
      if (scramble) din = 8'hFF;
      n = 0;
      while (sent !== 1'b1 && n < FRAME_BITS * DIV + 8) begin
         @(negedge clk);
         n++;
         if (scramble) din = 8'($urandom);
      end
      check("sent_latency", 32'(n), 32'(FRAME_BITS * DIV));
      if (hold_extra >= 0) begin
         for (int i = 0; i < hold_extra; i++) begin
            @(negedge clk);
            check("ack_hold", 32'({sent, busy, sout}), 32'b111);
         end
         send = 1'b0;
      end
      @(negedge clk);
      check("sent_drop", 32'({sent, busy}), 32'b00);
   endtask

   // Start a frame and reset it during data bit 3.
   task automatic reset_mid_frame(input logic [7:0] b);
      logic [7:0] dropped;
      din  = b;
      send = 1'b1;
      exp_q.push_back(b);
      @(negedge clk);
      send = 1'b0;
      repeat (DIV + 3 * DIV + 1) @(negedge clk);
      check("data_bit3_value", 32'({sout, busy}), 32'({b[3], 1'b1}));
      rst     = 1'b1;
      dropped = exp_q.pop_back();
      @(negedge clk);
      check("reset_mid_frame", 32'({sout, busy, sent}), 32'b100);
      rst = 1'b0;
      @(negedge clk);
      check("no_resume_after_reset", 32'({sout, busy, sent}), 32'b100);
   endtask

   // Stimulus.
   initial begin
      logic [10:0] expf;
      int          err[11];
      int          mode, gap;
      logic [7:0]  b;

      rst = 1'b1; send = 1'b0; din = '0;
      rst_s = 1'b1; send_s = 1'b0; din_s = '0;
      repeat (2) @(negedge clk);
      check("reset_state", 32'({sout, busy, sent}), 32'b100);
      rst = 1'b0;
      @(negedge clk);

      // Directed patterns, back to back.
      send_frame(8'h55, -1, 1'b0);
      send_frame(8'h07, -1, 1'b0);
      send_frame(8'h00, -1, 1'b0);
      repeat (3) @(negedge clk);

      // Din changes mid-frame must not affect the latched byte.
      send_frame(8'hA3, -1, 1'b1);

      // Send held high for ~200 cycles: one frame only.
      send_frame(8'h5A, 200 - FRAME_BITS * DIV, 1'b0);
      repeat (2) @(negedge clk);

      // Reset during data bit 3, then a clean frame.
      reset_mid_frame(8'h30);
      send_frame(8'h3C, -1, 1'b0);

      // Reset has priority over Send.
      rst  = 1'b1;
      send = 1'b1;
      din  = 8'h99;
      @(negedge clk);
      check("reset_over_send", 32'({sout, busy, sent}), 32'b100);
      rst  = 1'b0;
      send = 1'b0;
      @(negedge clk);
      check("idle_after_reset_send", 32'({sout, busy, sent}), 32'b100);

      // Random traffic.
      for (int f = 0; f < 24; f++) begin
         b    = 8'($urandom);
         mode = int'($urandom_range(0, 2));
         gap  = int'($urandom_range(0, 3));
         case (mode)
            0:       send_frame(b, -1, 1'b0);
            1:       send_frame(b, int'($urandom_range(0, 6)), 1'b0);
            default: send_frame(b, -1, 1'b1);
         endcase
         repeat (gap) @(negedge clk);
      end
      repeat (4) @(negedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      // Bit widths at the full-size divider.
      rst_s = 1'b0;
      @(negedge clk);
      check("slow_reset_state", 32'({sout_s, busy_s, sent_s}), 32'b100);
      din_s  = 8'hC1;
      send_s = 1'b1;
      @(negedge clk);
      send_s = 1'b0;
      expf   = frame_of(8'hC1);
      for (int k = 0; k < 11; k++) err[k] = 0;
      for (int i = 0; i < FRAME_BITS * DIV_SLOW; i++) begin
         if (sout_s !== expf[i / DIV_SLOW]) err[i / DIV_SLOW]++;
         @(negedge clk);
      end
      check("slow_sent_at_end", 32'({sent_s, sout_s}), 32'b11);
      for (int k = 0; k < FRAME_BITS; k++) check("slow_bit_width", 32'(err[k]), 32'd0);
      @(negedge clk);
      check("slow_sent_pulse", 32'({sent_s, busy_s}), 32'b00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
